// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single vga_adapter write port among NREQ
// drawers. Round-robin at burst granularity; the owner keeps the port until
// it flags last, drops req, or sits idle for TIMEOUT cycles. A one-cycle GAP
// follows every burst so there is always a turnaround between owners.
module vga_plot_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     vld,
   input  logic [NREQ-1:0]     last,
   input  logic [8*NREQ-1:0]   x_in,
   input  logic [7*NREQ-1:0]   y_in,
   input  logic [3*NREQ-1:0]   col_in,
   output logic [NREQ-1:0]     gnt,
   output logic [7:0]          x,
   output logic [6:0]          y,
   output logic [2:0]          col,
   output logic                plot,
   output logic                busy,
   output logic                timeout_err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t               state;
   logic [PW-1:0]        ptr;      // current owner while in OWN, last owner otherwise
   logic [PW-1:0]        pick;
   logic [CW-1:0]        to_cnt;

   // Packed per-requester views of the flat pixel buses
   logic [NREQ-1:0][7:0] xs;
   logic [NREQ-1:0][6:0] ys;
   logic [NREQ-1:0][2:0] cs;

   assign xs = x_in;
   assign ys = y_in;
   assign cs = col_in;

   logic own_vld, own_last, own_req, burst_done, to_hit;

   assign own_vld    = vld[ptr];
   assign own_last   = last[ptr];
   assign own_req    = req[ptr];
   // last beats a coincident timeout; an aborted burst raises no error
   assign burst_done = (own_vld && own_last) || !own_req;
   assign to_hit     = !own_vld && (to_cnt == CW'(TIMEOUT - 1));

   // Round-robin search: first requester above ptr, wrapping modulo NREQ.
   // Scanning downward lets the nearest candidate overwrite farther ones.
   always_comb begin
      int idx;
      idx  = 0;
      pick = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) pick = PW'(idx);
      end
   end

   // Arbiter FSM with registered grant and vga_adapter outputs
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         ptr         <= PW'(NREQ - 1);
         to_cnt      <= '0;
         gnt         <= '0;
         x           <= '0;
         y           <= '0;
         col         <= '0;
         plot        <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               plot <= 1'b0;
               if (|req) begin
                  gnt       <= '0;
                  gnt[pick] <= 1'b1;
                  busy      <= 1'b1;
                  ptr       <= pick;
                  to_cnt    <= '0;
                  state     <= OWN;
               end
            end
            OWN: begin
               plot <= own_vld;
               if (own_vld) begin
                  x      <= xs[ptr];
                  y      <= ys[ptr];
                  col    <= cs[ptr];
                  to_cnt <= '0;
               end else if (to_cnt != CW'(TIMEOUT)) begin
                  to_cnt <= to_cnt + 1'b1;
               end
               if (burst_done || to_hit) begin
                  gnt         <= '0;
                  busy        <= 1'b0;
                  state       <= GAP;
                  timeout_err <= !burst_done;
               end
            end
            GAP: begin
               plot  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter (NREQ=4, TIMEOUT=1023).
module tb_vga_plot_arbiter;
   localparam int N  = 4;
   localparam int TO = 1023;

   logic           CLOCK_50 = 1'b0;
   logic           resetn   = 1'b0;
   logic [N-1:0]   req, vld, last;
   logic [8*N-1:0] x_in;
   logic [7*N-1:0] y_in;
   logic [3*N-1:0] col_in;
   logic [N-1:0]   gnt;
   logic [7:0]     x;
   logic [6:0]     y;
   logic [2:0]     col;
   logic           plot, busy, timeout_err;

   int total = 0;
   int bad   = 0;

   vga_plot_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req), .vld(vld), .last(last),
      .x_in(x_in), .y_in(y_in), .col_in(col_in), .gnt(gnt), .x(x), .y(y),
      .col(col), .plot(plot), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #1000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // advance one clock and sample 1 time unit after the edge
   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic idle_inputs();
      req = '0; vld = '0; last = '0; x_in = '0; y_in = '0; col_in = '0;
   endtask

   task automatic set_pix(input int i, input logic [7:0] xv, input logic [6:0] yv,
                          input logic [2:0] cv);
      x_in[8*i +: 8] = xv;
      y_in[7*i +: 7] = yv;
      col_in[3*i +: 3] = cv;
   endtask

   task automatic apply_reset();
      idle_inputs();
      resetn = 1'b0;
      step();
      step();
      #2 resetn = 1'b1;
      step();
   endtask

   // reference round-robin choice: first requester above p, wrapping
   function automatic int rr_pick(input int p, input logic [N-1:0] m);
      for (int k = 1; k <= N; k++)
         if (m[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      #3;
      total++;
      if ({gnt, plot, busy, timeout_err} !== '0) begin
         bad++; $display("FAIL rst_ctrl got=%0h exp=0", {gnt, plot, busy, timeout_err});
      end
      total++;
      if ({x, y, col} !== '0) begin
         bad++; $display("FAIL rst_pix got=%0h exp=0", {x, y, col});
      end
      #2 resetn = 1'b1;
      step();
   endtask

   task automatic test_single_burst();
      int xv[3];
      xv = '{2, 3, 4};
      apply_reset();
      req = 4'b0001;
      step();
      total++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || plot !== 1'b0) begin
         bad++; $display("FAIL sb_grant got=%b/%b/%b exp=0001/1/0", gnt, busy, plot);
      end
      for (int p = 0; p < 3; p++) begin
         vld  = 4'b0001;
         last = (p == 2) ? 4'b0001 : 4'b0000;
         set_pix(0, 8'(xv[p]), 7'd100, 3'b110);
         step();
         total++;
         if (plot !== 1'b1 || x !== 8'(xv[p]) || y !== 7'd100 || col !== 3'b110) begin
            bad++; $display("FAIL sb_pix%0d got=%b/%0d/%0d/%b exp=1/%0d/100/110", p, plot, x, y, col, xv[p]);
         end
         total++;
         if (gnt !== ((p == 2) ? 4'b0000 : 4'b0001) || busy !== (p != 2)) begin
            bad++; $display("FAIL sb_gnt%0d got=%b/%b", p, gnt, busy);
         end
      end
      idle_inputs();
      step();
      total++;
      if (plot !== 1'b0 || gnt !== 4'b0000 || x !== 8'd4) begin
         bad++; $display("FAIL sb_gap got=%b/%b/%0d exp=0/0000/4", plot, gnt, x);
      end
   endtask

   task automatic test_round_robin();
      int n, exp_o, last_cyc, cyc;
      apply_reset();
      for (int i = 0; i < N; i++) set_pix(i, 8'(10 + i), 7'(i), 3'(i));
      req = 4'b1111;
      n = 0; exp_o = N - 1; last_cyc = -100; cyc = 0;
      for (int c = 0; c < 80 && n < 5; c++) begin
         vld  = gnt;   // each drawer answers its grant with a single-pixel burst
         last = gnt;
         step();
         cyc++;
         total++;
         if ($countones(gnt) > 1) begin
            bad++; $display("FAIL rr_onehot got=%b exp=onehot0", gnt);
         end
         if (plot) begin
            exp_o = (exp_o + 1) % N;
            total++;
            if (x !== 8'(10 + exp_o)) begin
               bad++; $display("FAIL rr_order got=%0d exp=%0d", x, 10 + exp_o);
            end
            if (n > 0) begin
               total++;
               if (cyc - last_cyc < 3) begin
                  bad++; $display("FAIL rr_spacing got=%0d exp>=3", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            n++;
         end
      end
      total++;
      if (n != 5) begin
         bad++; $display("FAIL rr_count got=%0d exp=5", n);
      end
      idle_inputs();
      step(); step(); step();
   endtask

   task automatic test_timeout();
      int held;
      logic err_seen;
      apply_reset();
      req = 4'b1100;
      step();
      total++;
      if (gnt !== 4'b0100) begin
         bad++; $display("FAIL to_grant got=%b exp=0100", gnt);
      end
      held = 1; err_seen = 1'b0;
      for (int c = 0; c < 1100; c++) begin
         step();
         if (gnt !== 4'b0100) break;
         held++;
         if (timeout_err) err_seen = 1'b1;
      end
      total++;
      if (held != TO) begin
         bad++; $display("FAIL to_hold got=%0d exp=%0d", held, TO);
      end
      total++;
      if (err_seen) begin
         bad++; $display("FAIL to_early_err got=1 exp=0");
      end
      total++;
      if (timeout_err !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) begin
         bad++; $display("FAIL to_revoke got=%b/%b/%b exp=1/0000/0", timeout_err, gnt, busy);
      end
      step();
      total++;
      if (timeout_err !== 1'b0) begin
         bad++; $display("FAIL to_pulse got=%b exp=0", timeout_err);
      end
      step();
      total++;
      if (gnt !== 4'b1000) begin
         bad++; $display("FAIL to_next got=%b exp=1000", gnt);
      end
      idle_inputs();
      step(); step(); step();
   endtask

   task automatic test_nonowner();
      logic       v1;
      logic [7:0] xv, exp_x;
      apply_reset();
      req = 4'b0010;
      step();
      total++;
      if (gnt !== 4'b0010) begin
         bad++; $display("FAIL no_grant got=%b exp=0010", gnt);
      end
      req = 4'b0011;   // requester 0 joins late; must wait for the next arbitration
      exp_x = 8'd0;
      for (int c = 0; c < 20; c++) begin
         v1 = 1'($urandom_range(0, 1));
         xv = 8'($urandom_range(0, 76));
         vld = {2'b00, v1, 1'b1};
         set_pix(0, 8'd77, 7'd5, 3'd1);
         set_pix(1, xv, 7'd6, 3'd2);
         step();
         if (v1) exp_x = xv;
         total++;
         if (plot !== v1 || x !== exp_x) begin
            bad++; $display("FAIL no_pix got=%b/%0d exp=%b/%0d", plot, x, v1, exp_x);
         end
         total++;
         if (x === 8'd77 || gnt !== 4'b0010) begin
            bad++; $display("FAIL no_leak got=%0d/%b exp=!77/0010", x, gnt);
         end
      end
      vld = 4'b0011; last = 4'b0010;
      set_pix(1, 8'd50, 7'd6, 3'd2);
      step();
      total++;
      if (plot !== 1'b1 || x !== 8'd50 || gnt !== 4'b0000) begin
         bad++; $display("FAIL no_last got=%b/%0d/%b exp=1/50/0000", plot, x, gnt);
      end
      req = 4'b0001; vld = '0; last = '0;
      step(); step();
      total++;
      if (gnt !== 4'b0001) begin
         bad++; $display("FAIL no_next got=%b exp=0001", gnt);
      end
      idle_inputs();
      step(); step(); step();
   endtask

   task automatic test_abort_reset();
      apply_reset();
      req = 4'b0001;
      step();
      vld = 4'b0001;
      set_pix(0, 8'd20, 7'd1, 3'd1);
      step();
      total++;
      if (plot !== 1'b1 || x !== 8'd20) begin
         bad++; $display("FAIL ab_p1 got=%b/%0d exp=1/20", plot, x);
      end
      req = 4'b0000;   // abort while the second pixel is still valid
      set_pix(0, 8'd21, 7'd1, 3'd1);
      step();
      total++;
      if (plot !== 1'b1 || x !== 8'd21 || gnt !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         bad++; $display("FAIL ab_p2 got=%b/%0d/%b/%b/%b exp=1/21/0000/0/0", plot, x, gnt, busy, timeout_err);
      end
      vld = '0;
      step();
      total++;
      if (plot !== 1'b0 || timeout_err !== 1'b0 || gnt !== 4'b0000) begin
         bad++; $display("FAIL ab_gap got=%b/%b/%b exp=0/0/0000", plot, timeout_err, gnt);
      end
      req = 4'b0010;
      step(); step();
      total++;
      if (gnt !== 4'b0010) begin
         bad++; $display("FAIL ab_regrant got=%b exp=0010", gnt);
      end
      vld = 4'b0010;
      set_pix(1, 8'd30, 7'd2, 3'd3);
      step();
      total++;
      if (plot !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL ab_pre got=%b/%b exp=1/1", plot, busy);
      end
      #2 resetn = 1'b0;
      #1;
      total++;
      if (plot !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
         bad++; $display("FAIL ab_async got=%b/%b/%b exp=0/0000/0", plot, gnt, busy);
      end
      idle_inputs();
      req = 4'b1111;
      #2 resetn = 1'b1;
      step();
      total++;
      if (gnt !== 4'b0001) begin
         bad++; $display("FAIL ab_prio got=%b exp=0001", gnt);
      end
      idle_inputs();
      step(); step(); step();
   endtask

   task automatic test_last_timeout();
      logic err_seen, lost;
      apply_reset();
      req = 4'b0001;
      step();
      err_seen = 1'b0; lost = 1'b0;
      for (int k = 1; k < TO; k++) begin
         vld = '0;
         step();
         if (timeout_err) err_seen = 1'b1;
         if (gnt !== 4'b0001) lost = 1'b1;
      end
      total++;
      if (lost) begin
         bad++; $display("FAIL lt_early got=lost exp=held");
      end
      vld = 4'b0001; last = 4'b0001;
      set_pix(0, 8'd99, 7'd9, 3'd5);
      step();
      total++;
      if (plot !== 1'b1 || x !== 8'd99 || gnt !== 4'b0000 || timeout_err !== 1'b0) begin
         bad++; $display("FAIL lt_last got=%b/%0d/%b/%b exp=1/99/0000/0", plot, x, gnt, timeout_err);
      end
      step();
      total++;
      if (err_seen || timeout_err !== 1'b0) begin
         bad++; $display("FAIL lt_err got=1 exp=0");
      end
      idle_inputs();
      step(); step();
   endtask

   task automatic test_random();
      logic [N-1:0] pending, g, prev_g, req_drv;
      int           len[N], sent[N];
      int           model_ptr, pk;
      logic         dv, done;
      logic [7:0]   dx, ex;
      logic [6:0]   dy, ey;
      logic [2:0]   dc, ec;
      apply_reset();
      model_ptr = N - 1;
      ex = '0; ey = '0; ec = '0;
      prev_g = '0;
      for (int r = 0; r < 8; r++) begin
         pending = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            len[i] = $urandom_range(1, 4);
            sent[i] = 0;
         end
         done = 1'b0;
         for (int c = 0; c < 300 && !done; c++) begin
            g = gnt;
            req = pending;
            vld = '0; last = '0;
            dv = 1'b0; dx = '0; dy = '0; dc = '0;
            for (int i = 0; i < N; i++) begin
               set_pix(i, 8'($urandom), 7'($urandom), 3'($urandom));
               if (g[i] && pending[i]) begin
                  if ($urandom_range(0, 3) != 0) begin
                     vld[i]  = 1'b1;
                     last[i] = (sent[i] == len[i] - 1);
                     dv = 1'b1;
                     dx = x_in[8*i +: 8]; dy = y_in[7*i +: 7]; dc = col_in[3*i +: 3];
                     sent[i]++;
                     if (last[i]) pending[i] = 1'b0;
                  end
               end else begin
                  vld[i]  = 1'($urandom_range(0, 1));
                  last[i] = 1'($urandom_range(0, 1));
               end
            end
            req_drv = req;
            step();
            if (dv) begin
               ex = dx; ey = dy; ec = dc;
            end
            total++;
            if (plot !== dv || {x, y, col} !== {ex, ey, ec}) begin
               bad++; $display("FAIL rnd_pix got=%b/%0d/%0d/%0d exp=%b/%0d/%0d/%0d", plot, x, y, col, dv, ex, ey, ec);
            end
            total++;
            if ($countones(gnt) > 1) begin
               bad++; $display("FAIL rnd_onehot got=%b exp=onehot0", gnt);
            end
            if (gnt !== '0 && prev_g === '0) begin
               pk = rr_pick(model_ptr, req_drv);
               total++;
               if (pk < 0 || gnt !== (4'b0001 << pk)) begin
                  bad++; $display("FAIL rnd_grant got=%b exp_idx=%0d", gnt, pk);
               end
               if (pk >= 0) model_ptr = pk;
            end
            prev_g = gnt;
            if (pending == '0 && gnt == '0) done = 1'b1;
         end
         total++;
         if (!done) begin
            bad++; $display("FAIL rnd_round%0d got=stuck exp=done", r);
         end
      end
      idle_inputs();
      step(); step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_burst();
      test_round_robin();
      test_timeout();
      test_nonowner();
      test_abort_reset();
      test_last_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single vga_adapter write port (x, y, colour, plot) among up to NREQ sprite/scoreboard drawers, e.g. the mole drawer, scoreboard drawer and background clear.
- Round-robin arbitration at burst granularity: a granted drawer owns the port until it flags its last pixel, drops its request, or stalls past a timeout.
- Outputs are registered and drive vga_adapter directly.
- Sits between the drawers and vga_adapter in the top level, on CLOCK_50.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, max consecutive owner cycles without vld before grant is revoked (≥2).

Ports:
- CLOCK_50  in  1  system clock, all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester burst request, held high for the whole burst.
- vld  in  NREQ  per-requester pixel valid.
- last  in  NREQ  marks final pixel of burst; qualified by vld.
- x_in  in  8*NREQ  packed x, requester i at [8i+7:8i].
- y_in  in  7*NREQ  packed y, requester i at [7i+6:7i].
- col_in  in  3*NREQ  packed colour, requester i at [3i+2:3i].
- gnt  out  NREQ  one-hot registered grant.
- x  out  8  to vga_adapter.
- y  out  7  to vga_adapter.
- col  out  3  to vga_adapter.
- plot  out  1  to vga_adapter.
- busy  out  1  high while any grant is held.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (resetn low, async): gnt=0, x=0, y=0, col=0, plot=0, busy=0, timeout_err=0, state=IDLE, rr pointer=NREQ-1 so requester 0 wins the first arbitration, timeout counter=0.
- States: IDLE, OWN, GAP.
- IDLE:
  - If req≠0, choose the first set bit searching upward from (ptr+1) mod NREQ, wrapping around.
  - Next cycle: gnt one-hot, busy=1, owner/ptr updated, state=OWN.
  - If req=0, stay in IDLE.
- OWN: each cycle the output registers load from the owner's slice.
  - plot <= vld[o], x <= x_in[o], y <= y_in[o], col <= col_in[o].
  - Latency is one cycle from input pixel to plot.
  - x/y/col hold their last value when vld[o]=0.
  - vld from non-owners is ignored and never reaches plot.
- Burst end in OWN:
  - vld[o]&last[o]: that pixel is still plotted. Next cycle gnt=0, busy=0, state=GAP.
  - req[o] falls without last: abort. The current-cycle vld is still plotted. Then GAP, no error.
  - Timeout counter counts owner cycles with vld[o]=0 and clears on vld[o]=1. When it reaches TIMEOUT: gnt=0, busy=0, timeout_err=1 for one cycle, state=GAP.
  - If last and timeout coincide, last wins and no error is raised.
- GAP: exactly one cycle with plot=0 and gnt=0, then IDLE. This guarantees a turnaround cycle between owners.
- Fairness: ptr = last owner. With all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0.
- Burst spacing: minimum 3 cycles from the last pixel of one burst to the first possible pixel of the next (GAP, IDLE, then grant).
- A requester may assert vld in the same cycle gnt rises; that pixel is accepted.
- Single-pixel burst (vld&last on the first owned cycle) is legal.
- Widths:
  - The timeout counter is clog2(TIMEOUT+1) bits and saturates; it does not wrap.
  - ptr is clog2(NREQ) bits, with modulo-NREQ wrap for non-power-of-2 NREQ.
- req changes from non-owners during OWN have no effect until the next IDLE.
- Mid-operation reset: all outputs clear immediately (async), and plot drops the same instant.

Test Plan:
- Reset, then req=4'b0001 with a 3-pixel burst (x=2,3,4, y=100, col=3'b110, last on 3rd) → gnt=0001 one cycle after req; plot high 3 consecutive cycles with x=2,3,4 delayed one cycle; gnt=0 after the last pixel; busy falls.
- req=4'b1111 held, each requester sends a 1-pixel burst with x=10+i → grant order 0,1,2,3,0; plot pulses separated by ≥3 cycles; no two gnt bits ever high together.
- Requester 2 granted, then vld stays low for TIMEOUT=1023 cycles → gnt[2] drops, timeout_err pulses exactly 1 cycle, next arbitration picks requester 3 if requesting.
- Requester 1 owner; requester 0 drives vld=1 with x=77 → x never equals 77 and plot reflects only vld[1].
- Owner drops req mid-burst after 2 pixels → exactly 2 plots, GAP, timeout_err=0; assert resetn=0 mid-burst → plot, gnt and busy go 0 without a clock edge; after release, requester 0 has priority.
- Last and timeout in the same cycle (vld&last arrives when the counter would hit TIMEOUT) → pixel plotted, timeout_err stays 0.
